// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among
// NUM_REQ byte requesters, with message locking and baud_div ownership.
//
// Ports:
//   clock_i, resetn_i   clock and async active-low reset
//   cfg_baud_div_i      requested divider; applied only while fully idle
//   baud_div_o          divider currently driven to the UART
//   req_valid_i/_data_i/_last_i  per-requester byte stream
//   req_ready_o         one-hot accept strobe (LOAD cycle of the owner)
//   grant_o             one-hot current owner, 0 when unlocked
//   txen_o, tx_data_o   one-cycle transmit strobe and byte to the UART
//   tx_ing_i            UART transmit-in-progress
//   busy_o              arbiter not idle
//   timeout_err_o       one-cycle pulse on start or hold timeout
module uart_tx_arbiter #(
    parameter int          NUM_REQ       = 4,
    parameter logic [11:0] BAUD_DIV_RST  = 12'd87,
    parameter int          START_TIMEOUT = 16,
    parameter int          HOLD_TIMEOUT  = 4096
) (
    input  logic                   clock_i,
    input  logic                   resetn_i,
    input  logic [11:0]            cfg_baud_div_i,
    output logic [11:0]            baud_div_o,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*8-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   txen_o,
    output logic [7:0]             tx_data_o,
    input  logic                   tx_ing_i,
    output logic                   busy_o,
    output logic                   timeout_err_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(HOLD_TIMEOUT + 1);

    // Timeouts fire in the last allowed cycle of the waiting state, the
    // timer being 0 in the first cycle of that state.
    localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX    = '1;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_START,
        WAIT_DONE,
        HOLD
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               last_q, last_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [11:0]        baud_q, baud_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   owner_nxt;

    // First valid requester at or after rr_q, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_q) + k) % NUM_REQ);
            if (!pick_found && req_valid_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign owner_nxt = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_d          = rr_q;
        grant_d       = grant_q;
        last_d        = last_q;
        baud_d        = baud_q;
        txen_o        = 1'b0;
        tx_data_o     = 8'h00;
        req_ready_o   = '0;
        timeout_err_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The UART being busy externally blocks both the divider
                // update and arbitration.
                if (!tx_ing_i) begin
                    baud_d = cfg_baud_div_i;
                    if (pick_found) begin
                        owner_d = pick_idx;
                        grant_d = NUM_REQ'(1) << pick_idx;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                txen_o      = 1'b1;
                tx_data_o   = req_data_i[{owner_q, 3'b000} +: 8];
                req_ready_o = grant_q;
                last_d      = req_last_i[owner_q];
                state_d     = WAIT_START;
            end
            WAIT_START: begin
                if (tx_ing_i) begin
                    state_d = WAIT_DONE;
                end else if (timer_q >= START_LAST) begin
                    timeout_err_o = 1'b1;
                    grant_d       = '0;
                    rr_d          = owner_nxt;
                    state_d       = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_ing_i) begin
                    if (last_q) begin
                        grant_d = '0;
                        rr_d    = owner_nxt;
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (req_valid_i[owner_q]) begin
                    state_d = LOAD;
                end else if (timer_q >= HOLD_LAST) begin
                    timeout_err_o = 1'b1;
                    grant_d       = '0;
                    rr_d          = owner_nxt;
                    state_d       = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Cleared on every state change, saturating otherwise.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != TMR_MAX) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            last_q  <= 1'b0;
            timer_q <= '0;
            baud_q  <= BAUD_DIV_RST;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            baud_q  <= baud_d;
        end
    end

    assign baud_div_o = baud_q;
    assign grant_o    = grant_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a
// 10-cycle UART model and per-requester byte queues.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [11:0] cfg;
    logic [11:0] baud;
    logic [3:0]  rv = '0;
    logic [31:0] rd = '0;
    logic [3:0]  rl = '0;
    logic [3:0]  rdy;
    logic [3:0]  gnt;
    logic        txen;
    logic [7:0]  txd;
    logic        tx_ing;
    logic        busy;
    logic        toe;

    logic        uart_en;
    logic        manual_ing;
    logic        model_ing = 1'b0;
    int          mcnt = 0;

    assign tx_ing = uart_en ? model_ing : manual_ing;

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .clock_i        (clk),
        .resetn_i       (rstn),
        .cfg_baud_div_i (cfg),
        .baud_div_o     (baud),
        .req_valid_i    (rv),
        .req_data_i     (rd),
        .req_last_i     (rl),
        .req_ready_o    (rdy),
        .grant_o        (gnt),
        .txen_o         (txen),
        .tx_data_o      (txd),
        .tx_ing_i       (tx_ing),
        .busy_o         (busy),
        .timeout_err_o  (toe)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [8:0] rmem [4][16];
    int rtail [4] = '{default: 0};
    int rhead [4] = '{default: 0};
    int popped [4] = '{default: 0};

    logic [7:0] mon_data [64];
    logic [3:0] mon_gnt [64];
    logic [3:0] mon_rdy [64];
    int         mon_cyc [64];
    int         mon_n = 0;
    int         to_n = 0;
    int         to_cyc = 0;
    int         fall_n = 0;
    int         fall_cyc = 0;

    always @(posedge clk) cyc++;

    // Monitor plus UART model, sampled mid-cycle.
    always @(negedge clk) begin
        if (txen && mon_n < 64) begin
            mon_data[mon_n] = txd;
            mon_gnt[mon_n]  = gnt;
            mon_rdy[mon_n]  = rdy;
            mon_cyc[mon_n]  = cyc;
            mon_n++;
        end
        for (int i = 0; i < 4; i++)
            if (rdy[i]) popped[i]++;
        if (toe) begin
            to_n++;
            to_cyc = cyc;
        end
        if (!rstn) begin
            mcnt = 0;
            model_ing = 1'b0;
        end else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
                model_ing = 1'b0;
                fall_n++;
                fall_cyc = cyc;
            end
        end else if (txen && uart_en) begin
            model_ing = 1'b1;
            mcnt = 10;
        end
    end

    // Requesters present the head of their queue, advancing after LOAD.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            rhead[i] = popped[i];
            if (rhead[i] < rtail[i]) begin
                rv[i] = 1'b1;
                rd[8*i +: 8] = rmem[i][rhead[i]][7:0];
                rl[i] = rmem[i][rhead[i]][8];
            end else begin
                rv[i] = 1'b0;
                rd[8*i +: 8] = 8'h00;
                rl[i] = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        rmem[i][rtail[i]] = {l, d};
        rtail[i]++;
    endtask

    task automatic wait_txens(input int n, input int budget, input string tag);
        int k = 0;
        while (mon_n < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(mon_n >= n), 1);
    endtask

    task automatic wait_to(input int n, input int budget, input string tag);
        int k = 0;
        while (to_n < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(to_n >= n), 1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while ((busy || tx_ing) && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(busy), 0);
    endtask

    initial begin
        int base;
        int tob;
        int fb;
        int k;

        uart_en = 1'b1;
        manual_ing = 1'b0;
        cfg = 12'd100;
        rstn = 1'b0;
        tick();
        tick();
        chk("rst_txen", 32'(txen), 0);
        chk("rst_grant", 32'(gnt), 0);
        chk("rst_baud", 32'(baud), 87);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(rdy), 0);
        chk("rst_txdata", 32'(txd), 0);
        chk("rst_toe", 32'(toe), 0);
        rstn = 1'b1;
        tick();
        tick();
        chk("baud_idle_load", 32'(baud), 100);

        // Asynchronous reset in the middle of a byte.
        base = mon_n;
        push(0, 8'h01, 1'b1);
        wait_txens(base + 1, 20, "t1_txen");
        tick();
        tick();
        tick();
        chk("t1_busy_pre", 32'(busy), 1);
        chk("t1_grant_pre", 32'(gnt), 4'b0001);
        chk("t1_txing_pre", 32'(tx_ing), 1);
        #1 rstn = 1'b0;
        #1;
        chk("t1_rst_txen", 32'(txen), 0);
        chk("t1_rst_grant", 32'(gnt), 0);
        chk("t1_rst_baud", 32'(baud), 87);
        chk("t1_rst_busy", 32'(busy), 0);
        cfg = 12'd87;
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Round-robin with all four requesting.
        base = mon_n;
        push(0, 8'h10, 1'b1);
        push(0, 8'h10, 1'b1);
        push(1, 8'h11, 1'b1);
        push(2, 8'h12, 1'b1);
        push(3, 8'h13, 1'b1);
        wait_txens(base + 5, 200, "rr_txens");
        wait_idle(100, "rr_idle");
        chk("rr_count", 32'(mon_n - base), 5);
        for (int j = 0; j < 5; j++) begin
            k = j % 4;
            chk("rr_data", 32'(mon_data[base + j]), 32'(8'h10 + k));
            chk("rr_grant", 32'(mon_gnt[base + j]), 32'(1) << k);
            chk("rr_ready", 32'(mon_rdy[base + j]), 32'(1) << k);
        end

        // Message lock: req1 waits for req0's three bytes.
        base = mon_n;
        push(0, 8'hA5, 1'b0);
        push(0, 8'h5A, 1'b0);
        push(0, 8'hFF, 1'b1);
        wait_txens(base + 1, 40, "lock_first");
        push(1, 8'h11, 1'b1);
        wait_txens(base + 4, 200, "lock_txens");
        wait_idle(100, "lock_idle");
        chk("lock_d0", 32'(mon_data[base]), 8'hA5);
        chk("lock_d1", 32'(mon_data[base + 1]), 8'h5A);
        chk("lock_d2", 32'(mon_data[base + 2]), 8'hFF);
        chk("lock_d3", 32'(mon_data[base + 3]), 8'h11);
        chk("lock_g1", 32'(mon_gnt[base + 1]), 4'b0001);
        chk("lock_g2", 32'(mon_gnt[base + 2]), 4'b0001);
        chk("lock_g3", 32'(mon_gnt[base + 3]), 4'b0010);

        // Start timeout with tx_ing stuck low.
        uart_en = 1'b0;
        manual_ing = 1'b0;
        base = mon_n;
        tob = to_n;
        push(2, 8'h22, 1'b1);
        wait_txens(base + 1, 20, "sto_txen");
        wait_to(tob + 1, 40, "sto_pulse");
        chk("sto_delay", 32'(to_cyc - mon_cyc[base]), 16);
        tick();
        chk("sto_grant", 32'(gnt), 0);
        chk("sto_busy", 32'(busy), 0);
        chk("sto_toe_off", 32'(toe), 0);
        uart_en = 1'b1;
        base = mon_n;
        push(2, 8'h23, 1'b1);
        push(3, 8'h33, 1'b1);
        wait_txens(base + 2, 100, "sto_rr_txens");
        wait_idle(100, "sto_rr_idle");
        chk("sto_rr_first", 32'(mon_data[base]), 8'h33);
        chk("sto_rr_second", 32'(mon_data[base + 1]), 8'h23);

        // Hold timeout; req1 stays locked out meanwhile.
        base = mon_n;
        tob = to_n;
        fb = fall_n;
        push(2, 8'h2C, 1'b0);
        wait_txens(base + 1, 20, "hto_txen");
        k = 0;
        while (fall_n < fb + 1 && k < 40) begin
            tick();
            k++;
        end
        chk("hto_fall", 32'(fall_n >= fb + 1), 1);
        push(1, 8'h1B, 1'b1);
        wait_to(tob + 1, 4200, "hto_pulse");
        chk("hto_delay", 32'(to_cyc - fall_cyc), 4096);
        chk("hto_no_txen", 32'(mon_n - base), 1);
        chk("hto_owner", 32'(gnt), 4'b0100);
        tick();
        chk("hto_grant", 32'(gnt), 0);
        chk("hto_toe_off", 32'(toe), 0);
        wait_txens(base + 2, 20, "hto_next");
        chk("hto_next_data", 32'(mon_data[base + 1]), 8'h1B);
        chk("hto_next_grant", 32'(mon_gnt[base + 1]), 4'b0010);
        wait_idle(100, "hto_idle");

        // Baud change mid-message applies only once fully idle.
        base = mon_n;
        push(0, 8'h61, 1'b0);
        push(0, 8'h62, 1'b1);
        wait_txens(base + 1, 20, "baud_txen1");
        cfg = 12'd434;
        tick();
        tick();
        chk("baud_msg_a", 32'(baud), 87);
        wait_txens(base + 2, 60, "baud_txen2");
        chk("baud_msg_b", 32'(baud), 87);
        k = 0;
        while (busy && k < 60) begin
            tick();
            k++;
        end
        chk("baud_release", 32'(busy), 0);
        chk("baud_first_idle", 32'(baud), 87);
        tick();
        chk("baud_applied", 32'(baud), 434);

        // External tx_ing in IDLE blocks arbitration and baud update.
        uart_en = 1'b0;
        manual_ing = 1'b1;
        cfg = 12'd200;
        base = mon_n;
        push(0, 8'h0E, 1'b1);
        for (int j = 0; j < 5; j++) tick();
        chk("ext_grant", 32'(gnt), 0);
        chk("ext_busy", 32'(busy), 0);
        chk("ext_baud", 32'(baud), 434);
        chk("ext_no_txen", 32'(mon_n - base), 0);
        uart_en = 1'b1;
        wait_txens(base + 1, 20, "ext_txen");
        chk("ext_data", 32'(mon_data[base]), 8'h0E);
        chk("ext_baud_new", 32'(baud), 200);
        wait_idle(100, "ext_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
